// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes host bitstream words onto a prog_clk-gated
// configuration chain, with an optional replay pass that checks ccff_tail.
// Ports:
//   prog_clk, pReset       : sole clock, synchronous active-high reset
//   start, verify_en       : begin a load (IDLE only), request a verify pass
//   bs_data/valid/ready    : host word handshake, bit 0 shifted first
//   ccff_head, chain_en    : registered serial bit and chain clock enable
//   ccff_tail              : bit returning from the end of the chain
//   busy, done             : activity flag, one-cycle completion pulse
//   verify_err, err_idx    : sticky mismatch flag, index of first mismatch
module ccff_chain_loader #(
    parameter int CHAIN_LEN  = 32,
    parameter int WORD_WIDTH = 8
) (
    input  logic                         prog_clk,
    input  logic                         pReset,
    input  logic                         start,
    input  logic                         verify_en,
    input  logic [WORD_WIDTH-1:0]        bs_data,
    input  logic                         bs_valid,
    output logic                         bs_ready,
    output logic                         ccff_head,
    output logic                         chain_en,
    input  logic                         ccff_tail,
    output logic                         busy,
    output logic                         done,
    output logic                         verify_err,
    output logic [$clog2(CHAIN_LEN)-1:0] err_idx
);

    localparam int WPP = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int IW  = $clog2(CHAIN_LEN);
    localparam int SW  = $clog2(WORD_WIDTH + 1);
    localparam int CW  = $clog2(2 * WPP + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(CHAIN_LEN - 1);
    localparam logic [SW-1:0] SR_FULL  = SW'(WORD_WIDTH);
    localparam logic [CW-1:0] WORDS_1P = CW'(WPP);
    localparam logic [CW-1:0] WORDS_2P = CW'(2 * WPP);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY
    } state_t;

    state_t                state_q;
    logic                  verify_q;
    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    logic [SW-1:0]         sr_cnt_q, sr_cnt_d;
    logic [IW-1:0]         pass_cnt_q, pass_cnt_d;
    logic [CW-1:0]         words_q;
    logic                  fin_q;
    logic                  head_q;
    logic                  en_q;
    logic [IW-1:0]         emit_idx_q;
    logic                  emit_vfy_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [IW-1:0]         err_idx_q;

    logic                  emit;
    logic                  last_bit;
    logic [CW-1:0]         words_total;
    logic                  accept;

    // A new word may land on the same edge that empties the buffer, either
    // because its last bit leaves or because the pass boundary truncates it.
    always_comb begin
        emit        = (sr_cnt_q != '0);
        last_bit    = emit && (pass_cnt_q == LAST_IDX);
        words_total = verify_q ? WORDS_2P : WORDS_1P;
        bs_ready    = (state_q != IDLE) && (words_q < words_total)
                      && ((sr_cnt_q <= SW'(1)) || last_bit);
        accept      = bs_valid && bs_ready;
    end

    always_comb begin
        sr_d       = sr_q;
        sr_cnt_d   = sr_cnt_q;
        pass_cnt_d = pass_cnt_q;
        if (emit) begin
            sr_d       = sr_q >> 1;
            sr_cnt_d   = last_bit ? '0 : sr_cnt_q - SW'(1);
            pass_cnt_d = last_bit ? '0 : pass_cnt_q + IW'(1);
        end
        if (accept) begin
            sr_d     = bs_data;
            sr_cnt_d = SR_FULL;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q    <= IDLE;
            verify_q   <= 1'b0;
            sr_q       <= '0;
            sr_cnt_q   <= '0;
            pass_cnt_q <= '0;
            words_q    <= '0;
            fin_q      <= 1'b0;
            head_q     <= 1'b0;
            en_q       <= 1'b0;
            emit_idx_q <= '0;
            emit_vfy_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        verify_q   <= verify_en;
                        err_q      <= 1'b0;
                        err_idx_q  <= '0;
                        pass_cnt_q <= '0;
                        words_q    <= '0;
                        sr_cnt_q   <= '0;
                        fin_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD, VERIFY: begin
                    sr_q       <= sr_d;
                    sr_cnt_q   <= sr_cnt_d;
                    pass_cnt_q <= pass_cnt_d;
                    if (accept) begin
                        words_q <= words_q + CW'(1);
                    end
                    if (last_bit) begin
                        if (state_q == LOAD && verify_q) begin
                            state_q <= VERIFY;
                        end else begin
                            fin_q <= 1'b1;
                        end
                    end
                    // Hold one extra cycle so the final compare lands
                    // before done is raised.
                    if (fin_q) begin
                        state_q <= IDLE;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            en_q <= emit;
            if (emit) begin
                head_q     <= sr_q[0];
                emit_idx_q <= pass_cnt_q;
                emit_vfy_q <= (state_q == VERIFY);
            end

            // While a replayed bit sits on the head, the tail shows the
            // same-index bit from the first pass.
            if (en_q && emit_vfy_q && !err_q && (ccff_tail != head_q)) begin
                err_q     <= 1'b1;
                err_idx_q <= emit_idx_q;
            end
        end
    end

    assign ccff_head  = head_q;
    assign chain_en   = en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign verify_err = err_q;
    assign err_idx    = err_idx_q;

endmodule
